// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter: grants one of 8 requesters, holds until release, then rotates priority.
// Optional hold-timeout forced release enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_8 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic [2:0] ptr,
    output logic       tmo
);

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range
        $error("rr_arbiter_8: HOLD_MAX must be in 2..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     gnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             vld_nxt;
    logic [IDX_W-1:0] ptr_nxt;

    logic             found_c;
    logic [IDX_W-1:0] win_c;
    logic [IDX_W-1:0] cand_c;
    logic             release_c;
    logic             drop_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             tmo_nxt;
    logic             timeout_c;

    // Owner-driven release wins over the timeout on the same cycle.
    assign timeout_c = (cnt == HOLD_LAST) && !release_c;
    assign drop_c    = release_c || timeout_c;
`else
    assign tmo    = 1'b0;
    assign drop_c = release_c;
`endif

    assign release_c = done || !req[gnt_idx];

    // First set request at or after ptr, wrapping modulo 8.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        cand_c  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand_c = ptr + IDX_W'(i);
            if (!found_c && req[cand_c]) begin
                found_c = 1'b1;
                win_c   = cand_c;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        vld_nxt   = gnt_vld;
        ptr_nxt   = ptr;
`ifdef ARB_TIMEOUT_EN
        cnt_nxt   = cnt;
        tmo_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (found_c) begin
                    gnt_nxt   = N'(1) << win_c;
                    idx_nxt   = win_c;
                    vld_nxt   = 1'b1;
                    state_nxt = BUSY;
`ifdef ARB_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            BUSY: begin
                if (drop_c) begin
                    gnt_nxt   = '0;
                    idx_nxt   = '0;
                    vld_nxt   = 1'b0;
                    ptr_nxt   = gnt_idx + IDX_W'(1);
                    state_nxt = IDLE;
`ifdef ARB_TIMEOUT_EN
                    tmo_nxt   = timeout_c;
`endif
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                idx_nxt   = '0;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            gnt_vld <= 1'b0;
            ptr     <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt     <= '0;
            tmo     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            gnt_vld <= vld_nxt;
            ptr     <= ptr_nxt;
`ifdef ARB_TIMEOUT_EN
            cnt     <= cnt_nxt;
            tmo     <= tmo_nxt;
`endif
        end
    end

endmodule
